// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: start/done controller that sequences the feature-map load,
// the per-layer row sweep and the write-back of a multi-layer inference.
//
// Ports
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   start               begin an inference (accepted in IDLE, or on the edge ending DONE)
//   abort               cancel a running inference
//   cfg_num_layers      layers to run, clamped to 1..NUM_LAYERS on an accepted start
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//   ifmap_write_enable  selects the input vector as memory write data
//   mem_write_enable    memory write strobe
//   mem_addr            feature-map memory read address
//   weight_layer        weight-store layer index
//   weight_row          weight-store row index
//   acc_enable          accelerator accumulate enable
//   acc_reset           accelerator synchronous accumulator clear
module nn_layer_sequencer #(
   parameter int NUM_LAYERS = 4,
   parameter int VEC_LEN    = 32,
   parameter int ADDR_W     = 5,
   parameter int LAYER_W    = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [LAYER_W:0]   cfg_num_layers,
   output logic               busy,
   output logic               done,
   output logic               ifmap_write_enable,
   output logic               mem_write_enable,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [LAYER_W-1:0] weight_layer,
   output logic [ADDR_W-1:0]  weight_row,
   output logic               acc_enable,
   output logic               acc_reset
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, WB, DONE} state_t;

   localparam logic [LAYER_W:0]  MAX_L    = (LAYER_W+1)'(NUM_LAYERS);
   localparam logic [LAYER_W:0]  ONE_L    = (LAYER_W+1)'(1);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(VEC_LEN-1);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  row_q, row_d;
   logic [LAYER_W-1:0] layer_q, layer_d;
   logic [LAYER_W:0]   nl_q, nl_d;
   logic [LAYER_W:0]   clamped;
   logic               accept;
   logic               last_layer;

   assign clamped    = (cfg_num_layers == '0) ? ONE_L :
                       (cfg_num_layers > MAX_L) ? MAX_L : cfg_num_layers;
   assign accept     = start && !abort;
   assign last_layer = ({1'b0, layer_q} == nl_q - ONE_L);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         layer_q <= '0;
         nl_q    <= ONE_L;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         layer_q <= layer_d;
         nl_q    <= nl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      layer_d = layer_q;
      nl_d    = nl_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = LOAD;
               nl_d    = clamped;
               row_d   = '0;
               layer_d = '0;
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            row_d   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            state_d = (row_q == LAST_ROW) ? WB : RUN;
         end
         WB: begin
            row_d   = '0;
            state_d = last_layer ? DONE : RUN;
            layer_d = last_layer ? layer_q : layer_q + 1'b1;
         end
         DONE: begin
            // the edge that ends DONE may already launch the next inference
            state_d = accept ? LOAD : IDLE;
            nl_d    = accept ? clamped : nl_q;
            row_d   = '0;
            layer_d = '0;
         end
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         row_d   = '0;
         layer_d = '0;
      end
   end

   // outputs are a pure decode of the registered state, so reset clears them at once
   always_comb begin
      busy               = (state_q != IDLE);
      done               = (state_q == DONE);
      ifmap_write_enable = (state_q == LOAD);
      mem_write_enable   = (state_q == LOAD) || (state_q == WB);
      acc_reset          = (state_q == LOAD) || (state_q == WB);
      acc_enable         = (state_q == RUN);
      mem_addr           = (state_q == RUN) ? row_q : '0;
      weight_row         = (state_q == RUN) ? row_q : '0;
      weight_layer       = (state_q == RUN) ? layer_q : '0;
   end
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: directed and random checks of nn_layer_sequencer against a cycle-offset model.
module tb_nn_layer_sequencer;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] cfg_num_layers = '0;
   logic       busy, done, ifmap_write_enable, mem_write_enable, acc_enable, acc_reset;
   logic [4:0] mem_addr, weight_row;
   logic [1:0] weight_layer;

   int n_cmp = 0;
   int n_bad = 0;
   int n_step = 0;
   int done_at = -1;
   int mwe_cnt = 0;
   int dcyc;

   // model: active flag, cycle offset since the accepting edge, clamped layer count
   bit m_act = 0;
   int m_t = 0;
   int m_l = 1;

   nn_layer_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .cfg_num_layers(cfg_num_layers), .busy(busy), .done(done),
      .ifmap_write_enable(ifmap_write_enable), .mem_write_enable(mem_write_enable),
      .mem_addr(mem_addr), .weight_layer(weight_layer), .weight_row(weight_row),
      .acc_enable(acc_enable), .acc_reset(acc_reset)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] pack();
      return {busy, done, ifmap_write_enable, mem_write_enable, acc_enable, acc_reset,
              weight_layer, mem_addr, weight_row};
   endfunction

   function automatic int clamp(input int c);
      return (c == 0) ? 1 : (c > 4) ? 4 : c;
   endfunction

   // expected outputs from the cycle offset: 1 = load, then 33 cycles per layer, then done
   function automatic logic [17:0] model_out();
      int u, k, r;
      if (!m_act) return '0;
      if (m_t == 1) return {6'b101101, 12'd0};
      if (m_t == 2 + 33 * m_l) return {6'b110000, 12'd0};
      u = m_t - 2;
      k = u / 33;
      r = u % 33;
      if (r < 32) return {6'b100010, k[1:0], r[4:0], r[4:0]};
      return {6'b100101, 12'd0};
   endfunction

   task automatic model_edge(input bit s, input bit a, input int c);
      if (!m_act) begin
         if (s && !a) begin m_act = 1; m_t = 1; m_l = clamp(c); end
      end else if (a) m_act = 0;
      else if (m_t == 2 + 33 * m_l) begin
         if (s) begin m_t = 1; m_l = clamp(c); end
         else m_act = 0;
      end else m_t++;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, n_step);
      end
   endtask

   task automatic step(input bit s, input bit a, input int c);
      start = s;
      abort = a;
      cfg_num_layers = c[2:0];
      @(negedge clk);
      chk("outs", {14'd0, pack()}, {14'd0, model_out()});
      if (done) done_at = n_step;
      if (mem_write_enable) mwe_cnt++;
      @(posedge clk);
      if (reset_n) model_edge(s, a, c);
      n_step++;
      #1;
   endtask

   // one inference from an idle model; returns the done cycle relative to the start edge
   task automatic run_inf(input int c, output int d);
      int s0, n;
      s0 = n_step;
      done_at = -1;
      step(1, 0, c);
      n = 0;
      while (m_act && n < 300) begin
         step(0, 0, c);
         n++;
      end
      if (n >= 300) chk("timeout", 32'd1, 32'd0);
      d = (done_at < 0) ? -1 : done_at - s0;
   endtask

   initial begin
      // reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset", {14'd0, pack()}, 32'd0);
      end
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(0, 0, 0);

      // start held continuously: one inference, next accepted on the edge ending DONE
      mwe_cnt = 0;
      done_at = -1;
      begin
         int s0;
         s0 = n_step;
         for (int i = 0; i < 135; i++) step(1, 0, 4);
         chk("done_cyc_held", done_at - s0, 134);
         chk("mwe_cnt", mwe_cnt, 5);
      end
      chk("busy_135", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 300 && m_act; i++) step(0, 0, 4);

      run_inf(4, dcyc);
      chk("done_cyc_4", dcyc, 134);
      run_inf(0, dcyc);
      chk("done_cyc_0", dcyc, 35);
      run_inf(7, dcyc);
      chk("done_cyc_7", dcyc, 134);
      run_inf(2, dcyc);
      chk("done_cyc_2", dcyc, 68);

      // abort at row 10 of layer 1
      done_at = -1;
      step(1, 0, 4);
      for (int i = 0; i < 200 && m_t != 45; i++) step(0, 0, 4);
      chk("abort_row", {27'd0, weight_row}, 32'd10);
      step(0, 1, 4);
      for (int i = 0; i < 5; i++) step(0, 0, 4);
      chk("abort_no_done", done_at, -1);
      run_inf(4, dcyc);
      chk("done_after_abort", dcyc, 134);

      // start and abort together in idle
      for (int i = 0; i < 5; i++) step(1, 1, 3);
      chk("start_abort_idle", {31'd0, busy}, 32'd0);

      // random traffic
      for (int i = 0; i < 5000; i++)
         step($urandom_range(7) == 0, $urandom_range(199) == 0, $urandom_range(7));
      for (int i = 0; i < 300 && m_act; i++) step(0, 1, 0);

      // asynchronous reset in the middle of a layer
      step(1, 0, 4);
      for (int i = 0; i < 200 && m_t != 50; i++) step(0, 0, 4);
      reset_n = 1'b0;
      #1;
      chk("async_rst", {14'd0, pack()}, 32'd0);
      m_act = 0;
      for (int i = 0; i < 2; i++) step(0, 0, 4);
      reset_n = 1'b1;
      step(0, 0, 4);
      run_inf(3, dcyc);
      chk("done_after_rst", dcyc, 101);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
